// File: rtl/spi_cmd_scheduler.sv
// Purpose: executes completed SPI frames against the LED/scan registers and a key FIFO, and stages the reply byte.
// Latency: command effects and reply land on the 2nd clk edge after the first edge that samples commReady=1.
// Backpressure: keyReady = !full; a key offered while full is dropped and sets sticky ovf. One command per commReady pulse.
//
// Ports:
//   clk, rst (sync, active-low)        - system clock / reset
//   commReady, commAdr, commData       - frame from the sck domain (adr/data stable while commReady=1)
//   keyValid, keyCode, keyReady        - key scanner push interface
//   replyData                          - byte shifted out in the next SPI frame
//   ledReg, scanPeriod                 - control registers
//   cmdStrobe, cmdErr                  - one-cycle pulse per executed command / rejected command
module spi_cmd_scheduler #(
    parameter int         COMM_WIDTH   = 8,
    parameter int         ADR_WIDTH    = 3,
    parameter int         REPLY_WIDTH  = 8,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] SCAN_DEFAULT = 8'd50
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   commReady,
    input  logic [ADR_WIDTH-1:0]   commAdr,
    input  logic [COMM_WIDTH-1:0]  commData,
    input  logic                   keyValid,
    input  logic [7:0]             keyCode,
    output logic                   keyReady,
    output logic [REPLY_WIDTH-1:0] replyData,
    output logic [7:0]             ledReg,
    output logic [7:0]             scanPeriod,
    output logic                   cmdStrobe,
    output logic                   cmdErr
);

    localparam int         PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        EXEC     = 2'd2
    } state_t;

    state_t                 state;
    logic                   ready_meta;
    logic                   primed;
    logic [ADR_WIDTH-1:0]   adr_lat;
    logic [COMM_WIDTH-1:0]  data_lat;

    logic [7:0]             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [3:0]             count;
    logic                   ovf;
    logic                   last_err;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic [REPLY_WIDTH-1:0] status;

    logic                   exec_pop;
    logic                   exec_clear;
    logic                   exec_err;
    logic                   exec_led;
    logic                   exec_scan;
    logic [REPLY_WIDTH-1:0] exec_reply;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == 4'd0);
    assign keyReady = !full;
    assign push     = keyValid && !full;
    assign status   = REPLY_WIDTH'({ovf, last_err, empty, full, 1'b0, count[2:0]});

    // Command decode; only active while the FSM sits in EXEC.
    always_comb begin
        exec_reply = status;
        exec_err   = 1'b0;
        exec_pop   = 1'b0;
        exec_clear = 1'b0;
        exec_led   = 1'b0;
        exec_scan  = 1'b0;
        if (state == EXEC) begin
            case (adr_lat)
                ADR_WIDTH'(0): ;
                ADR_WIDTH'(1): exec_led = 1'b1;
                ADR_WIDTH'(2): begin
                    if (data_lat == '0) exec_err  = 1'b1;
                    else                exec_scan = 1'b1;
                end
                ADR_WIDTH'(3): ;
                ADR_WIDTH'(4): begin
                    if (!empty) begin
                        exec_pop   = 1'b1;
                        exec_reply = REPLY_WIDTH'(mem[rd_ptr]);
                    end else begin
                        exec_reply = '0;
                        exec_err   = 1'b1;
                    end
                end
                ADR_WIDTH'(5): exec_clear = 1'b1;
                default:       exec_err   = 1'b1;
            endcase
        end
    end

    // ready_meta is the first synchroniser stage; the FSM/latch registers form
    // the second. primed blocks the first post-reset cycle, where ready_meta
    // still holds its cleared value, so a frame flagged across reset release
    // is never mistaken for a fresh one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= WAIT_LOW;
            ready_meta <= 1'b0;
            primed     <= 1'b0;
            adr_lat    <= '0;
            data_lat   <= '0;
            replyData  <= '0;
            ledReg     <= 8'd0;
            scanPeriod <= SCAN_DEFAULT;
            cmdStrobe  <= 1'b0;
            cmdErr     <= 1'b0;
            last_err   <= 1'b0;
        end else begin
            ready_meta <= commReady;
            primed     <= 1'b1;
            cmdStrobe  <= 1'b0;
            cmdErr     <= 1'b0;
            case (state)
                WAIT_LOW: begin
                    if (primed && !ready_meta) state <= IDLE;
                end
                IDLE: begin
                    if (ready_meta) begin
                        adr_lat  <= commAdr;
                        data_lat <= commData;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    replyData <= exec_reply;
                    cmdStrobe <= 1'b1;
                    cmdErr    <= exec_err;
                    last_err  <= exec_err;
                    if (exec_led)  ledReg     <= 8'(data_lat);
                    if (exec_scan) scanPeriod <= 8'(data_lat);
                    state <= WAIT_LOW;
                end
                default: state <= WAIT_LOW;
            endcase
        end
    end

    // FIFO bookkeeping. CLEAR overrides a same-cycle push and overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 4'd0;
            ovf    <= 1'b0;
        end else if (exec_clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 4'd0;
            ovf    <= 1'b0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
            if (exec_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, exec_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (keyValid && full) ovf <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= keyCode;
    end

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Purpose: directed + randomized check of spi_cmd_scheduler against a queue-based reference model.
// Latency: commands issued with commReady rising before edge E; results sampled on the negedge after E+2.
// Backpressure: keyReady compared against model queue occupancy before every push.
module tb_spi_cmd_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       commReady;
    logic [2:0] commAdr;
    logic [7:0] commData;
    logic       keyValid;
    logic [7:0] keyCode;
    logic       keyReady;
    logic [7:0] replyData;
    logic [7:0] ledReg;
    logic [7:0] scanPeriod;
    logic       cmdStrobe;
    logic       cmdErr;

    int n_cmp = 0;
    int n_bad = 0;
    int strobe_cnt = 0;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_lerr;
    logic [7:0] m_led;
    logic [7:0] m_scan;

    localparam int DEPTH = 4;

    spi_cmd_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .commReady  (commReady),
        .commAdr    (commAdr),
        .commData   (commData),
        .keyValid   (keyValid),
        .keyCode    (keyCode),
        .keyReady   (keyReady),
        .replyData  (replyData),
        .ledReg     (ledReg),
        .scanPeriod (scanPeriod),
        .cmdStrobe  (cmdStrobe),
        .cmdErr     (cmdErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmdStrobe === 1'b1) strobe_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        int n = mq.size();
        return {m_ovf, m_lerr, (n == 0), (n == DEPTH), 1'b0, 3'(n)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_lerr = 1'b0;
        m_led  = 8'h00;
        m_scan = 8'd50;
    endtask

    // One key offered for one cycle, with no command executing.
    task automatic push_key(input logic [7:0] kc);
        @(negedge clk);
        chk("keyReady", keyReady, (mq.size() < DEPTH));
        keyValid = 1'b1;
        keyCode  = kc;
        @(negedge clk);
        keyValid = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(kc);
        else                   m_ovf = 1'b1;
    endtask

    // Full frame: raise commReady, check results after E+2, hold, drop, confirm one strobe.
    task automatic send_cmd(input logic [2:0] adr, input logic [7:0] data,
                            input bit with_key, input logic [7:0] kc, input int hold);
        logic [7:0] exp_reply;
        bit         exp_err;
        bit         pre_full;
        int         s0;

        pre_full  = (mq.size() == DEPTH);
        exp_reply = m_status();
        exp_err   = 1'b0;
        case (adr)
            3'd1: m_led = data;
            3'd2: if (data == 8'd0) exp_err = 1'b1; else m_scan = data;
            3'd4: begin
                if (mq.size() != 0) exp_reply = mq.pop_front();
                else begin exp_reply = 8'h00; exp_err = 1'b1; end
            end
            3'd5: ;
            3'd6, 3'd7: exp_err = 1'b1;
            default: ;
        endcase
        if (adr == 3'd5) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (with_key) begin
            if (pre_full) m_ovf = 1'b1;
            else          mq.push_back(kc);
        end
        m_lerr = exp_err;

        @(negedge clk);
        commAdr   = adr;
        commData  = data;
        commReady = 1'b1;
        s0        = strobe_cnt;
        @(negedge clk);
        @(negedge clk);
        chk("strobe_early", cmdStrobe, 1'b0);
        if (with_key) begin
            keyValid = 1'b1;
            keyCode  = kc;
        end
        @(negedge clk);
        keyValid = 1'b0;
        chk("cmdStrobe", cmdStrobe, 1'b1);
        chk("cmdErr", cmdErr, exp_err);
        chk("replyData", replyData, exp_reply);
        chk("ledReg", ledReg, m_led);
        chk("scanPeriod", scanPeriod, m_scan);
        repeat (hold) @(negedge clk);
        commReady = 1'b0;
        commAdr   = 3'($urandom);
        commData  = 8'($urandom);
        repeat (4) @(negedge clk);
        chk("strobe_count", strobe_cnt - s0, 1);
        chk("reply_hold", replyData, exp_reply);
    endtask

    initial begin
        logic [7:0] d;
        rst       = 1'b0;
        commReady = 1'b1;
        commAdr   = 3'd1;
        commData  = 8'hFF;
        keyValid  = 1'b0;
        keyCode   = 8'h00;
        model_reset();

        // Reset with a frame still flagged: must not execute on release.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_strobes", strobe_cnt, 0);
        chk("rst_led", ledReg, 8'h00);
        chk("rst_scan", scanPeriod, 8'd50);
        chk("rst_reply", replyData, 8'h00);
        chk("rst_keyReady", keyReady, 1'b1);
        chk("rst_cmdErr", cmdErr, 1'b0);
        commReady = 1'b0;
        repeat (4) @(negedge clk);

        // WRITE_LED: reply is the pre-write status (empty, count 0).
        send_cmd(3'd1, 8'hA5, 1'b0, 8'h00, 0);
        chk("led_a5", ledReg, 8'hA5);
        chk("led_reply", replyData, 8'h20);

        // Fill FIFO then overflow.
        push_key(8'h11);
        push_key(8'h22);
        push_key(8'h33);
        push_key(8'h44);
        @(negedge clk);
        chk("full_keyReady", keyReady, 1'b0);
        push_key(8'h55);
        send_cmd(3'd3, 8'h00, 1'b0, 8'h00, 0);
        chk("status_full_ovf", replyData, 8'h94);

        // Drain in order, then underflow.
        send_cmd(3'd4, 8'h00, 1'b0, 8'h00, 0);
        chk("pop1", replyData, 8'h11);
        send_cmd(3'd4, 8'h00, 1'b0, 8'h00, 0);
        chk("pop2", replyData, 8'h22);
        send_cmd(3'd4, 8'h00, 1'b0, 8'h00, 0);
        chk("pop3", replyData, 8'h33);
        send_cmd(3'd4, 8'h00, 1'b0, 8'h00, 0);
        chk("pop4", replyData, 8'h44);
        send_cmd(3'd4, 8'h00, 1'b0, 8'h00, 0);
        chk("pop_empty", replyData, 8'h00);
        send_cmd(3'd0, 8'h00, 1'b0, 8'h00, 0);
        chk("nop_lasterr", replyData, 8'hE0);

        // CLEAR beats a same-cycle push; ovf cleared.
        send_cmd(3'd5, 8'h00, 1'b1, 8'h77, 0);
        send_cmd(3'd3, 8'h00, 1'b0, 8'h00, 0);
        chk("after_clear", replyData, 8'h20);
        send_cmd(3'd4, 8'h00, 1'b0, 8'h00, 0);

        // Rejected commands and a long commReady high period.
        send_cmd(3'd2, 8'h00, 1'b0, 8'h00, 0);
        chk("scan_unchanged", scanPeriod, 8'd50);
        send_cmd(3'd6, 8'h3C, 1'b0, 8'h00, 0);
        send_cmd(3'd7, 8'hC3, 1'b0, 8'h00, 0);
        send_cmd(3'd2, 8'h80, 1'b0, 8'h00, 100);

        // Push and POP in the same cycle, with a partly filled FIFO.
        push_key(8'hA1);
        push_key(8'hA2);
        send_cmd(3'd4, 8'h00, 1'b1, 8'hA3, 0);
        chk("pop_push_head", replyData, 8'hA1);

        // Randomized mix of pushes and commands.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                    push_key(8'($urandom));
            end else begin
                d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
                send_cmd(3'($urandom_range(0, 7)), d, bit'($urandom_range(0, 1)),
                         8'($urandom), int'($urandom_range(0, 3)));
            end
        end

        // Reset while idle returns everything to reset values.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        chk("rst2_led", ledReg, 8'h00);
        chk("rst2_scan", scanPeriod, 8'd50);
        chk("rst2_reply", replyData, 8'h00);
        chk("rst2_keyReady", keyReady, 1'b1);
        repeat (4) @(negedge clk);
        send_cmd(3'd3, 8'h00, 1'b0, 8'h00, 0);
        chk("rst2_status", replyData, 8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
